sonic_distance_filter: RTL and testbench

- Sits directly downstream of the ultrasonic echo-measurement stage.
- Consumes raw distance samples (0.01 cm units, one per trigger period) and smooths them with a power-of-two moving average.
- Makes a hysteretic, confirmed obstacle decision and drives the car's stop request.
- Flags a sensor fault when samples stop arriving.

---
 rtl/sonic_pkg.sv | 36 +++
 rtl/sonic_distance_filter_moving_avg.sv | 92 +++++++++
 rtl/sonic_distance_filter.sv | 157 +++++++++++++++
 tb/tb_sonic_distance_filter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sonic_pkg.sv
// ============================================================================
//  Module      : sonic_pkg
//  Description : Shared types and constants for the ultrasonic distance
//                filter: decision-state encoding, sample width, LSB unit and
//                the input clip helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sonic_pkg;

    // Width of every distance value in the filter path
    localparam int DIST_W = 20;

    // One LSB is 0.01 cm, i.e. 100 um
    localparam int LSB_UM = 100;

    // Decision state, also exported on the debug/LED port
    typedef enum logic [1:0] {
        INIT  = 2'd0,
        CLEAR = 2'd1,
        NEAR  = 2'd2,
        FAULT = 2'd3
    } state_t;

    // Saturate a raw reading to the usable sensor range
    function automatic logic [DIST_W-1:0] clip_dist(
        input logic [DIST_W-1:0] d,
        input logic [DIST_W-1:0] lim
    );
        return (d > lim) ? lim : d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sonic_distance_filter_moving_avg.sv
// ============================================================================
//  Module      : moving_avg
//  Description : Clips incoming samples, keeps a 2^AVG_LOG2 deep window with
//                a running sum and emits the truncated mean once the window
//                has been filled. Also exposes the mean that the current
//                sample will produce, so the decision logic can switch state
//                on the same edge that registers the average.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module moving_avg
    import sonic_pkg::*;
#(
    parameter int AVG_LOG2 = 2,
    parameter int DIST_MAX = 40000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic [DIST_W-1:0] i_dist_in,
    input  logic              i_dist_valid,
    output logic [DIST_W-1:0] o_avg_dist,
    output logic              o_avg_valid,
    output logic [DIST_W-1:0] o_nxt_avg,
    output logic              o_nxt_valid
);

    localparam int                c_depth     = 1 << AVG_LOG2;
    localparam int                c_sum_w     = DIST_W + AVG_LOG2;
    localparam int                c_fill_w    = AVG_LOG2 + 1;
    localparam logic [DIST_W-1:0] c_dist_max  = DIST_W'(DIST_MAX);
    localparam logic [c_fill_w-1:0] c_fill_full = c_fill_w'(c_depth);
    localparam logic [c_fill_w-1:0] c_fill_last = c_fill_w'(c_depth - 1);

    logic [DIST_W-1:0]   r_win [c_depth];
    logic [c_sum_w-1:0]  r_sum;
    logic [c_fill_w-1:0] r_fill;
    logic [DIST_W-1:0]   r_avg_dist;
    logic                r_avg_valid;

    logic [DIST_W-1:0]   w_sample;
    logic [c_sum_w-1:0]  w_sum_nxt;
    logic                w_fill_done;

    // Empty window slots hold zero, so subtracting the oldest entry is
    // harmless while the window is still filling.
    assign w_sample    = clip_dist(i_dist_in, c_dist_max);
    assign w_sum_nxt   = r_sum + c_sum_w'(w_sample) - c_sum_w'(r_win[c_depth-1]);
    assign w_fill_done = (r_fill >= c_fill_last);
    assign o_nxt_valid = i_dist_valid && w_fill_done && !i_flush;
    assign o_nxt_avg   = w_sum_nxt[c_sum_w-1:AVG_LOG2];

    // Window shift register, running sum and fill counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_depth; i++) r_win[i] <= '0;
            r_sum  <= '0;
            r_fill <= '0;
        end else if (i_flush) begin
            for (int i = 0; i < c_depth; i++) r_win[i] <= '0;
            r_sum  <= '0;
            r_fill <= '0;
        end else if (i_dist_valid) begin
            r_win[0] <= w_sample;
            for (int i = 1; i < c_depth; i++) r_win[i] <= r_win[i-1];
            r_sum <= w_sum_nxt;
            if (r_fill < c_fill_full) begin
                r_fill <= r_fill + c_fill_w'(1);
            end
        end
    end

    // Registered average and its one-cycle strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_avg_dist  <= '0;
            r_avg_valid <= 1'b0;
        end else begin
            r_avg_valid <= o_nxt_valid;
            if (o_nxt_valid) begin
                r_avg_dist <= o_nxt_avg;
            end
        end
    end

    assign o_avg_dist  = r_avg_dist;
    assign o_avg_valid = r_avg_valid;

endmodule

`default_nettype wire

// File: rtl/sonic_distance_filter.sv
// ============================================================================
//  Module      : sonic_distance_filter
//  Description : Smooths ultrasonic distance samples, makes a hysteretic and
//                confirmed obstacle decision driving the stop request, and
//                raises a fault when samples stop arriving.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sonic_distance_filter
    import sonic_pkg::*;
#(
    parameter int AVG_LOG2    = 2,
    parameter int DIST_MAX    = 40000,
    parameter int NEAR_TH     = 4000,
    parameter int FAR_TH      = 5000,
    parameter int CONFIRM     = 2,
    parameter int TIMEOUT_CYC = 25_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIST_W-1:0] i_dist_in,
    input  logic              i_dist_valid,
    output logic [DIST_W-1:0] o_avg_dist,
    output logic              o_avg_valid,
    output logic              o_stop,
    output logic              o_fault,
    output logic [1:0]        o_state
);

    localparam int                c_to_w    = $clog2(TIMEOUT_CYC + 1);
    localparam int                c_cf_w    = (CONFIRM > 1) ? $clog2(CONFIRM) : 1;
    localparam logic [c_to_w-1:0] c_to_max  = c_to_w'(TIMEOUT_CYC);
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT_CYC - 1);
    localparam logic [c_cf_w-1:0] c_cf_last = c_cf_w'(CONFIRM - 1);
    localparam logic [DIST_W-1:0] c_near_th = DIST_W'(NEAR_TH);
    localparam logic [DIST_W-1:0] c_far_th  = DIST_W'(FAR_TH);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_cf_w-1:0]   r_conf;
    logic [c_cf_w-1:0]   w_conf_nxt;
    logic [c_to_w-1:0]   r_tcnt;

    logic [DIST_W-1:0]   w_nxt_avg;
    logic                w_nxt_valid;
    logic                w_expire;

    // The expiry cycle is the one that would take the idle count to its
    // limit; a sample arriving in that very cycle cancels the timeout.
    assign w_expire = !i_dist_valid && (r_tcnt == c_to_last) && (r_state != FAULT);

    moving_avg #(
        .AVG_LOG2 (AVG_LOG2),
        .DIST_MAX (DIST_MAX)
    ) u_avg (
        .clk          (clk),
        .rst          (rst),
        .i_flush      (w_expire),
        .i_dist_in    (i_dist_in),
        .i_dist_valid (i_dist_valid),
        .o_avg_dist   (o_avg_dist),
        .o_avg_valid  (o_avg_valid),
        .o_nxt_avg    (w_nxt_avg),
        .o_nxt_valid  (w_nxt_valid)
    );

    // Idle-cycle counter, saturating at the timeout limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tcnt <= '0;
        end else if (i_dist_valid) begin
            r_tcnt <= '0;
        end else if (r_tcnt != c_to_max) begin
            r_tcnt <= r_tcnt + c_to_w'(1);
        end
    end

    // Decision state and confirm counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= INIT;
            r_conf  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_conf  <= w_conf_nxt;
        end
    end

    // Next-state logic: hysteresis band holds state and clears confirm
    always_comb begin
        w_state_nxt = r_state;
        w_conf_nxt  = r_conf;
        case (r_state)
            INIT: begin
                if (w_expire) begin
                    w_state_nxt = FAULT;
                    w_conf_nxt  = '0;
                end else if (w_nxt_valid) begin
                    w_state_nxt = (w_nxt_avg < c_far_th) ? NEAR : CLEAR;
                    w_conf_nxt  = '0;
                end
            end
            CLEAR: begin
                if (w_expire) begin
                    w_state_nxt = FAULT;
                    w_conf_nxt  = '0;
                end else if (w_nxt_valid) begin
                    if (w_nxt_avg < c_near_th) begin
                        if (r_conf == c_cf_last) begin
                            w_state_nxt = NEAR;
                            w_conf_nxt  = '0;
                        end else begin
                            w_conf_nxt = r_conf + c_cf_w'(1);
                        end
                    end else begin
                        w_conf_nxt = '0;
                    end
                end
            end
            NEAR: begin
                if (w_expire) begin
                    w_state_nxt = FAULT;
                    w_conf_nxt  = '0;
                end else if (w_nxt_valid) begin
                    if (w_nxt_avg >= c_far_th) begin
                        if (r_conf == c_cf_last) begin
                            w_state_nxt = CLEAR;
                            w_conf_nxt  = '0;
                        end else begin
                            w_conf_nxt = r_conf + c_cf_w'(1);
                        end
                    end else begin
                        w_conf_nxt = '0;
                    end
                end
            end
            FAULT: begin
                if (i_dist_valid) begin
                    w_state_nxt = INIT;
                    w_conf_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = INIT;
                w_conf_nxt  = '0;
            end
        endcase
    end

    assign o_stop  = (r_state != CLEAR);
    assign o_fault = (r_state == FAULT);
    assign o_state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_sonic_distance_filter.sv
// ============================================================================
//  Module      : tb_sonic_distance_filter
//  Description : Self-checking bench for sonic_distance_filter: directed
//                vector table, hand-written timeout/reset sequences and
//                randomized samples against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sonic_distance_filter;

    localparam int T_TO  = 200;
    localparam int DMAX  = 40000;
    localparam int NTH   = 4000;
    localparam int FTH   = 5000;
    localparam int NCONF = 2;
    localparam int WIN   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] dist_in = '0;
    logic        dist_valid = 1'b0;
    logic [19:0] avg_dist;
    logic        avg_valid;
    logic        stop;
    logic        fault;
    logic [1:0]  state;

    sonic_distance_filter #(
        .AVG_LOG2    (2),
        .DIST_MAX    (DMAX),
        .NEAR_TH     (NTH),
        .FAR_TH      (FTH),
        .CONFIRM     (NCONF),
        .TIMEOUT_CYC (T_TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_dist_in    (dist_in),
        .i_dist_valid (dist_valid),
        .o_avg_dist   (avg_dist),
        .o_avg_valid  (avg_valid),
        .o_stop       (stop),
        .o_fault      (fault),
        .o_state      (state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: 0 INIT, 1 CLEAR, 2 NEAR, 3 FAULT
    int m_win[$];
    int m_avg;
    bit m_vld;
    int m_state;
    int m_conf;
    int m_idle;

    typedef struct {
        int gap;
        int din;
        bit ev;
        int eavg;
        int est;
    } vec_t;
    vec_t tbl[$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_win.delete();
        m_avg   = 0;
        m_vld   = 0;
        m_state = 0;
        m_conf  = 0;
        m_idle  = 0;
    endtask

    task automatic decide(int a);
        case (m_state)
            0: begin
                m_state = (a < FTH) ? 2 : 1;
                m_conf  = 0;
            end
            1: begin
                if (a < NTH) begin
                    m_conf++;
                    if (m_conf == NCONF) begin m_state = 2; m_conf = 0; end
                end else m_conf = 0;
            end
            2: begin
                if (a >= FTH) begin
                    m_conf++;
                    if (m_conf == NCONF) begin m_state = 1; m_conf = 0; end
                end else m_conf = 0;
            end
            default: ;
        endcase
    endtask

    task automatic model_step(bit v, int din);
        int s;
        int sum;
        m_vld = 0;
        if (v) begin
            s = (din > DMAX) ? DMAX : din;
            sum = 0;
            m_idle = 0;
            m_win.push_back(s);
            if (m_win.size() > WIN) void'(m_win.pop_front());
            if (m_state == 3) begin
                m_state = 0;
                m_conf  = 0;
            end else if (m_win.size() == WIN) begin
                foreach (m_win[i]) sum += m_win[i];
                m_avg = sum / WIN;
                m_vld = 1;
                decide(m_avg);
            end
        end else if (m_state != 3) begin
            m_idle++;
            if (m_idle >= T_TO) begin
                m_state = 3;
                m_conf  = 0;
                m_win.delete();
            end
        end
    endtask

    task automatic check_all();
        check("avg_valid", 32'(avg_valid), 32'(m_vld));
        check("avg_dist",  32'(avg_dist),  32'(m_avg));
        check("state",     32'(state),     32'(m_state));
        check("stop",      32'(stop),      32'(m_state != 1));
        check("fault",     32'(fault),     32'(m_state == 3));
    endtask

    // One clock cycle: drive, clock, then compare against the model
    task automatic cycle(bit v, int din);
        dist_valid = v;
        dist_in    = 20'(din);
        @(posedge clk);
        #1;
        model_step(v, din);
        check_all();
        dist_valid = 1'b0;
        dist_in    = '0;
    endtask

    task automatic sample(int gap, int din);
        repeat (gap) cycle(1'b0, 0);
        cycle(1'b1, din);
    endtask

    task automatic check_reset_values(string tag);
        check({tag, "_avg"},   32'(avg_dist),  32'd0);
        check({tag, "_valid"}, 32'(avg_valid), 32'd0);
        check({tag, "_stop"},  32'(stop),      32'd1);
        check({tag, "_fault"}, 32'(fault),     32'd0);
        check({tag, "_state"}, 32'(state),     32'd0);
    endtask

    initial begin
        int gap;
        int din;
        int r;

        // Directed vectors: {gap, din, expect avg_valid, expect avg, expect state}
        tbl.push_back('{20, 10000, 0, 0, 0});
        tbl.push_back('{20, 10000, 0, 0, 0});
        tbl.push_back('{20, 10000, 0, 0, 0});
        tbl.push_back('{20, 10000, 1, 10000, 1});
        tbl.push_back('{5, 2000, 1, 8000, 1});
        tbl.push_back('{5, 2000, 1, 6000, 1});
        tbl.push_back('{5, 2000, 1, 4000, 1});
        tbl.push_back('{5, 2000, 1, 2000, 1});
        tbl.push_back('{5, 2000, 1, 2000, 2});
        tbl.push_back('{3, 4500, 1, 2625, 2});
        tbl.push_back('{3, 4500, 1, 3250, 2});
        tbl.push_back('{3, 4500, 1, 3875, 2});
        tbl.push_back('{3, 4500, 1, 4500, 2});
        tbl.push_back('{3, 7300, 1, 5200, 2});
        tbl.push_back('{3, 1700, 1, 4500, 2});
        tbl.push_back('{3, 7300, 1, 5200, 2});
        tbl.push_back('{3, 1700, 1, 4500, 2});
        tbl.push_back('{3, 10100, 1, 5200, 2});
        tbl.push_back('{3, 1700, 1, 5200, 1});
        tbl.push_back('{2, 1034482, 1, 13375, 1});
        tbl.push_back('{2, 1034482, 1, 22950, 1});
        tbl.push_back('{2, 1034482, 1, 30425, 1});
        tbl.push_back('{2, 1034482, 1, 40000, 1});
        tbl.push_back('{0, 0, 1, 30000, 1});
        tbl.push_back('{0, 0, 1, 20000, 1});
        tbl.push_back('{0, 0, 1, 10000, 1});
        tbl.push_back('{0, 0, 1, 0, 1});
        tbl.push_back('{0, 0, 1, 0, 2});
        tbl.push_back('{0, 5000, 1, 1250, 2});
        tbl.push_back('{0, 5000, 1, 2500, 2});
        tbl.push_back('{0, 5000, 1, 3750, 2});
        tbl.push_back('{0, 5000, 1, 5000, 2});
        tbl.push_back('{0, 5000, 1, 5000, 1});

        // Power-on reset
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("por");
        rst = 1'b0;

        foreach (tbl[i]) begin
            sample(tbl[i].gap, tbl[i].din);
            check($sformatf("vec%0d_valid", i), 32'(avg_valid), 32'(tbl[i].ev));
            if (tbl[i].ev) check($sformatf("vec%0d_avg", i), 32'(avg_dist), 32'(tbl[i].eavg));
            check($sformatf("vec%0d_state", i), 32'(state), 32'(tbl[i].est));
            check($sformatf("vec%0d_stop", i), 32'(stop), 32'(tbl[i].est != 1));
        end

        // Sample landing exactly on the expiry cycle cancels the timeout
        repeat (T_TO - 1) cycle(1'b0, 0);
        check("pre_expiry_fault", 32'(fault), 32'd0);
        cycle(1'b1, 5000);
        check("expiry_race_fault", 32'(fault), 32'd0);
        check("expiry_race_state", 32'(state), 32'd1);

        // Full timeout: FAULT, then recovery through a fresh fill
        repeat (T_TO - 1) cycle(1'b0, 0);
        check("almost_timeout_fault", 32'(fault), 32'd0);
        cycle(1'b0, 0);
        check("timeout_fault", 32'(fault), 32'd1);
        check("timeout_stop",  32'(stop),  32'd1);
        check("timeout_state", 32'(state), 32'd3);
        repeat (5) cycle(1'b0, 0);
        check("fault_hold_state", 32'(state), 32'd3);
        sample(0, 6000);
        check("recover_state", 32'(state), 32'd0);
        check("recover_fault", 32'(fault), 32'd0);
        check("recover_valid", 32'(avg_valid), 32'd0);
        sample(1, 6000);
        sample(1, 6000);
        check("refill3_valid", 32'(avg_valid), 32'd0);
        sample(1, 6000);
        check("refill4_valid", 32'(avg_valid), 32'd1);
        check("refill4_avg",   32'(avg_dist),  32'd6000);
        check("refill4_state", 32'(state),     32'd1);

        // Into NEAR with one confirm pending, then an asynchronous reset
        sample(2, 1000);
        sample(2, 1000);
        sample(2, 1000);
        sample(2, 1000);
        check("pre_rst_near", 32'(state), 32'd2);
        sample(2, 20000);
        check("pre_rst_avg",  32'(avg_dist), 32'd5750);
        check("pre_rst_hold", 32'(state),    32'd2);
        #3;
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        sample(1, 7000);
        sample(1, 7000);
        sample(1, 7000);
        check("post_rst_fill_valid", 32'(avg_valid), 32'd0);
        check("post_rst_fill_state", 32'(state),     32'd0);
        sample(1, 7000);
        check("post_rst_first_valid", 32'(avg_valid), 32'd1);
        check("post_rst_first_avg",   32'(avg_dist),  32'd7000);
        check("post_rst_first_state", 32'(state),     32'd1);

        // Randomized samples against the reference model
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 19) == 0) gap = $urandom_range(T_TO - 2, T_TO + 2);
            else                            gap = $urandom_range(0, 6);
            r = $urandom_range(0, 7);
            if (r == 0)      din = $urandom_range(DMAX, 20'hFFFFF);
            else if (r <= 2) din = $urandom_range(NTH - 100, FTH + 100);
            else if (r == 3) din = $urandom_range(0, 3000);
            else             din = $urandom_range(0, 12000);
            sample(gap, din);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
